// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath.
// Holds the default widths, the integrator FSM states and the saturating adder.
package snn_pkg;

  localparam int DEF_WEIGHT_WIDTH  = 8;
  localparam int DEF_CURRENT_WIDTH = 16;

  typedef enum logic {
    RUN  = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Signed add clamped to the range of a cw-bit two's-complement value.
  // The work is done at 64 bits, so the sum of two in-range operands can never wrap.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 cw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (cw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/spike_addr_fifo.sv
// Synchronous queue of pending spike addresses.
// The head is read combinationally, so it can drive the RAM read address directly.
module spike_addr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  // The extra MSB on each pointer tells full apart from empty.
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/synaptic_integrator.sv
// Reads the weights of queued spikes from the synaptic RAM and sums them into a saturating input current.
// The sum is handed to the LIF core once per timestep.
module synaptic_integrator
  import snn_pkg::*;
#(
  parameter int NUM_SYNAPSES  = 256,
  parameter int WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
  parameter int CURRENT_WIDTH = DEF_CURRENT_WIDTH,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            spike_valid,
  input  logic [$clog2(NUM_SYNAPSES)-1:0] spike_addr,
  output logic                            spike_ready,
  input  logic                            step_end,
  input  logic                            ram_grant,
  output logic [$clog2(NUM_SYNAPSES)-1:0] ram_address,
  input  logic [WEIGHT_WIDTH-1:0]         ram_weight,
  output logic [CURRENT_WIDTH-1:0]        current_out,
  output logic                            current_valid,
  output logic                            current_sat,
  output logic                            step_overrun
);

  localparam int AW = $clog2(NUM_SYNAPSES);

  state_e                    state;
  state_e                    state_nxt;
  logic                      step_pending;
  logic                      sat_flag;
  logic signed [CURRENT_WIDTH-1:0] acc;
  logic signed [CURRENT_WIDTH-1:0] acc_nxt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AW-1:0]             fifo_head;
  logic                      push;
  logic                      pop;
  logic signed [63:0]        acc_ext;
  logic signed [63:0]        w_ext;
  logic signed [63:0]        raw_ext;
  logic signed [63:0]        sum_ext;
  logic                      clamp;

  assign spike_ready = ~rst & ~fifo_full & ~step_pending & (state == RUN);
  assign push        = spike_valid & spike_ready;
  assign pop         = (state == RUN) & ~fifo_empty & ram_grant;
  assign ram_address = fifo_empty ? '0 : fifo_head;

  spike_addr_fifo #(
    .WIDTH(AW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (spike_addr),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  // A clamp is detected by comparing the clamped sum with the unclamped one.
  always_comb begin
    acc_ext = 64'(acc);
    w_ext   = 64'($signed(ram_weight));
    raw_ext = acc_ext + w_ext;
    sum_ext = sat_add(acc_ext, w_ext, CURRENT_WIDTH);
    clamp   = (sum_ext != raw_ext);
    acc_nxt = $signed(sum_ext[CURRENT_WIDTH-1:0]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (step_pending && fifo_empty) state_nxt = EMIT;
      EMIT:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_pending  <= 1'b0;
      step_overrun  <= 1'b0;
      sat_flag      <= 1'b0;
      acc           <= '0;
      current_out   <= '0;
      current_valid <= 1'b0;
      current_sat   <= 1'b0;
    end else begin
      current_valid <= (state == EMIT);
      // A step that is still closing cannot take a second boundary; record it and drop it.
      if (step_end) begin
        if (step_pending || state == EMIT) step_overrun <= 1'b1;
        else                               step_pending <= 1'b1;
      end
      if (state == EMIT) begin
        current_out  <= acc;
        current_sat  <= sat_flag;
        acc          <= '0;
        sat_flag     <= 1'b0;
        step_pending <= 1'b0;
      end else if (pop) begin
        acc <= acc_nxt;
        if (clamp) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synaptic_integrator.sv
// Directed test of synaptic_integrator against an async-read weight array.
// A second instance with an 8-bit current exercises saturation.
module tb_synaptic_integrator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spike_valid = 1'b0;
  logic [7:0]  spike_addr = '0;
  logic        step_end = 1'b0;
  logic        ram_grant = 1'b0;

  logic        spike_ready, current_valid, current_sat, step_overrun;
  logic [7:0]  ram_address;
  logic [7:0]  ram_weight;
  logic [15:0] current_out;

  logic        spike_ready8, current_valid8, current_sat8, step_overrun8;
  logic [7:0]  ram_address8;
  logic [7:0]  ram_weight8;
  logic [7:0]  current_out8;

  logic [7:0]  wmem [256];
  int          errs = 0;
  int          checks = 0;
  int          vcount = 0;
  logic        prev_v = 1'b0;

  assign ram_weight  = wmem[ram_address];
  assign ram_weight8 = wmem[ram_address8];

  always #5 clk = ~clk;

  synaptic_integrator #(.NUM_SYNAPSES(256), .WEIGHT_WIDTH(8), .CURRENT_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .spike_valid(spike_valid), .spike_addr(spike_addr),
    .spike_ready(spike_ready), .step_end(step_end), .ram_grant(ram_grant),
    .ram_address(ram_address), .ram_weight(ram_weight), .current_out(current_out),
    .current_valid(current_valid), .current_sat(current_sat), .step_overrun(step_overrun)
  );

  synaptic_integrator #(.NUM_SYNAPSES(256), .WEIGHT_WIDTH(8), .CURRENT_WIDTH(8), .FIFO_DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .spike_valid(spike_valid), .spike_addr(spike_addr),
    .spike_ready(spike_ready8), .step_end(step_end), .ram_grant(ram_grant),
    .ram_address(ram_address8), .ram_weight(ram_weight8), .current_out(current_out8),
    .current_valid(current_valid8), .current_sat(current_sat8), .step_overrun(step_overrun8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts emit strobes and flags back-to-back strobes.
  always @(negedge clk) begin
    if (current_valid === 1'b1) begin
      vcount++;
      chk("valid_not_back_to_back", prev_v, 1'b0);
    end
    prev_v = current_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (current_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, current_valid, 1'b1);
  endtask

  initial begin
    int n0;
    int accepted;
    int n;
    for (int i = 0; i < 256; i++) wmem[i] = 8'd0;
    wmem[3] = 8'd10;
    wmem[7] = 8'hFC;
    wmem[1] = 8'd2;
    wmem[0] = 8'd100;

    // Reset
    rst = 1'b1;
    tick();
    chk("rst_current_out", current_out, 16'd0);
    chk("rst_current_valid", current_valid, 1'b0);
    chk("rst_current_sat", current_sat, 1'b0);
    chk("rst_step_overrun", step_overrun, 1'b0);
    chk("rst_spike_ready", spike_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", spike_ready, 1'b1);
    tick();

    // Spikes 3, 7, 3 with the grant held: 10 - 4 + 10 = 16
    ram_grant   = 1'b1;
    spike_valid = 1'b1;
    spike_addr  = 8'd3;
    chk("ready_spike0", spike_ready, 1'b1);
    tick();
    chk("acc_t_plus_1", dut.acc, 16'sd0);
    spike_addr = 8'd7;
    tick();
    chk("acc_t_plus_2", dut.acc, 16'sd10);
    spike_addr = 8'd3;
    tick();
    chk("acc_after_neg", dut.acc, 16'sd6);
    spike_valid = 1'b0;
    step_end    = 1'b1;
    n0 = vcount;
    tick();
    step_end = 1'b0;
    wait_valid("emit_basic");
    chk("basic_current_out", current_out, 16'd16);
    chk("basic_current_sat", current_sat, 1'b0);
    repeat (5) tick();
    chk("basic_single_valid", vcount, n0 + 1);

    // Empty step: step_end in cycle 0, strobe in cycle 3
    step_end = 1'b1;
    tick();
    step_end = 1'b0;
    chk("empty_c1_valid", current_valid, 1'b0);
    tick();
    chk("empty_c2_valid", current_valid, 1'b0);
    tick();
    chk("empty_c3_valid", current_valid, 1'b1);
    chk("empty_current_out", current_out, 16'd0);
    tick();
    chk("empty_c4_valid", current_valid, 1'b0);
    repeat (3) tick();

    // Backpressure: no grant, 9 spikes at weight 2 offered
    ram_grant   = 1'b0;
    accepted    = 0;
    spike_valid = 1'b1;
    spike_addr  = 8'd1;
    for (int i = 0; i < 9; i++) begin
      if (spike_ready === 1'b1) accepted++;
      tick();
    end
    chk("bp_accepted", accepted, 8);
    chk("bp_ready_low_full", spike_ready, 1'b0);
    chk("bp_head_addr", ram_address, 8'd1);
    ram_grant = 1'b1;
    n = 0;
    while (spike_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("bp_ready_after_grant", spike_ready, 1'b1);
    tick();
    spike_valid = 1'b0;
    step_end    = 1'b1;
    tick();
    step_end = 1'b0;
    wait_valid("emit_bp");
    chk("bp_current_out", current_out, 16'd18);
    repeat (3) tick();

    // Saturation on the 8-bit instance: 100 + 100 clamps at 127
    spike_valid = 1'b1;
    spike_addr  = 8'd0;
    tick();
    tick();
    spike_valid = 1'b0;
    step_end    = 1'b1;
    tick();
    step_end = 1'b0;
    wait_valid("emit_sat");
    chk("sat_current_out8", current_out8, 8'd127);
    chk("sat_current_sat8", current_sat8, 1'b1);
    chk("sat_current_out16", current_out, 16'd200);
    chk("sat_current_sat16", current_sat, 1'b0);
    repeat (3) tick();
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    step_end    = 1'b1;
    tick();
    step_end = 1'b0;
    wait_valid("emit_after_sat");
    chk("post_sat_current_out8", current_out8, 8'd100);
    chk("post_sat_current_sat8", current_sat8, 1'b0);
    repeat (3) tick();

    // Overrun: second step_end lands while the first is emitting
    chk("overrun_clear", step_overrun, 1'b0);
    n0 = vcount;
    step_end = 1'b1;
    tick();
    step_end = 1'b0;
    tick();
    step_end = 1'b1;
    tick();
    step_end = 1'b0;
    repeat (8) tick();
    chk("overrun_set", step_overrun, 1'b1);
    chk("overrun_single_valid", vcount, n0 + 1);

    // Reset while spikes are queued and a step is closing
    ram_grant   = 1'b0;
    spike_valid = 1'b1;
    spike_addr  = 8'd3;
    repeat (3) tick();
    spike_valid = 1'b0;
    step_end    = 1'b1;
    tick();
    step_end = 1'b0;
    rst      = 1'b1;
    tick();
    chk("midrst_ready_low", spike_ready, 1'b0);
    rst       = 1'b0;
    ram_grant = 1'b1;
    n0 = vcount;
    repeat (10) tick();
    chk("midrst_no_valid", vcount, n0);
    chk("midrst_fifo_empty", dut.u_fifo.empty, 1'b1);
    chk("midrst_ram_address", ram_address, 8'd0);
    chk("midrst_overrun_cleared", step_overrun, 1'b0);
    chk("midrst_current_out", current_out, 16'd0);
    chk("midrst_acc", dut.acc, 16'sd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
